trail_iir_pipe: RTL

//  Pipelined, parametrised successor to the single-cycle glow-trail IIR. Per pixel it merges a

---
 rtl/trail_iir_pipe.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/trail_iir_pipe.sv
// Glow-trail IIR merge: 3-stage valid/ready pipeline, runtime decay and four blend modes.
// Optional frame statistics are built when TRAIL_IIR_STATS_EN is defined.
module trail_iir_pipe #(
    parameter int Y_BITS      = 4,
    parameter int CR_BITS     = 2,
    parameter int CB_BITS     = 2,
    parameter int COLOR_DEPTH = 8,
    parameter int COEF_BITS   = 8,
    parameter int COEF_RST    = 252,
    parameter int THRESHOLD   = 11
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [COEF_BITS-1:0]   cfg_coef_in,
    input  logic [Y_BITS-1:0]      cfg_thresh_in,
    input  logic [1:0]             cfg_mode_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   sof_in,
    input  logic [COLOR_DEPTH-1:0] history_in,
    input  logic [COLOR_DEPTH-1:0] camera_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   sof_out,
    output logic [COLOR_DEPTH-1:0] update_out
`ifdef TRAIL_IIR_STATS_EN
    ,
    output logic [31:0]            stat_count_out,
    output logic                   stat_valid_out
`endif
);
    localparam int C_BITS = CR_BITS + CB_BITS;
    localparam int P_BITS = Y_BITS + COEF_BITS;

    logic [COEF_BITS-1:0] coef_q;
    logic [Y_BITS-1:0]    thresh_q;
    logic [1:0]           mode_q;

    logic                 v1, sof1;
    logic [Y_BITS-1:0]    hy1, th1;
    logic [C_BITS-1:0]    hc1;
    logic [COLOR_DEPTH-1:0] cam1;
    logic [COEF_BITS-1:0] coef1;
    logic [1:0]           mode1;

    logic                 v2, sof2;
    logic [Y_BITS-1:0]    hy2, th2, yd2;
    logic [C_BITS-1:0]    hc2;
    logic [COLOR_DEPTH-1:0] cam2;
    logic [1:0]           mode2;

    logic adv1, adv2, adv3, take_in;

    assign adv3      = !valid_out || ready_in;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign ready_out = adv1;
    assign take_in   = valid_in && adv1;

    // Shadow config: loaded only by an accepted start-of-frame beat.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            coef_q   <= COEF_BITS'(COEF_RST);
            thresh_q <= Y_BITS'(THRESHOLD);
            mode_q   <= 2'd0;
        end else if (take_in && sof_in) begin
            coef_q   <= cfg_coef_in;
            thresh_q <= cfg_thresh_in;
            mode_q   <= cfg_mode_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v1    <= 1'b0;
            sof1  <= 1'b0;
            hy1   <= '0;
            hc1   <= '0;
            cam1  <= '0;
            coef1 <= '0;
            th1   <= '0;
            mode1 <= 2'd0;
        end else if (adv1) begin
            v1    <= valid_in;
            sof1  <= valid_in && sof_in;
            hy1   <= history_in[COLOR_DEPTH-1 -: Y_BITS];
            hc1   <= history_in[C_BITS-1:0];
            cam1  <= camera_in;
            coef1 <= sof_in ? cfg_coef_in : coef_q;
            th1   <= sof_in ? cfg_thresh_in : thresh_q;
            mode1 <= sof_in ? cfg_mode_in : mode_q;
        end
    end

    logic [P_BITS-1:0] prod;
    assign prod = {{COEF_BITS{1'b0}}, hy1} * {{Y_BITS{1'b0}}, coef1};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v2    <= 1'b0;
            sof2  <= 1'b0;
            hy2   <= '0;
            hc2   <= '0;
            cam2  <= '0;
            yd2   <= '0;
            th2   <= '0;
            mode2 <= 2'd0;
        end else if (adv2) begin
            v2    <= v1;
            sof2  <= v1 && sof1;
            hy2   <= hy1;
            hc2   <= hc1;
            cam2  <= cam1;
            yd2   <= prod[P_BITS-1:COEF_BITS];
            th2   <= th1;
            mode2 <= mode1;
        end
    end

    logic [Y_BITS-1:0]      cy, ysat;
    logic [Y_BITS:0]        ysum;
    logic                   cam_ge;
    logic [COLOR_DEPTH-1:0] blend;
    logic                   from_cam;

    assign cy     = cam2[COLOR_DEPTH-1 -: Y_BITS];
    assign cam_ge = cy >= yd2;
    assign ysum   = {1'b0, yd2} + {1'b0, cy};
    assign ysat   = ysum[Y_BITS] ? {Y_BITS{1'b1}} : ysum[Y_BITS-1:0];

    always_comb begin
        blend    = cam2;
        from_cam = 1'b1;
        case (mode2)
            2'd0: begin
                from_cam = !(hy2 > th2);
                blend    = from_cam ? cam2 : {yd2, hc2};
            end
            2'd1: begin
                from_cam = cam_ge;
                blend    = cam_ge ? cam2 : {yd2, hc2};
            end
            2'd2: begin
                from_cam = cam_ge;
                blend    = {ysat, cam_ge ? cam2[C_BITS-1:0] : hc2};
            end
            default: begin
                from_cam = 1'b1;
                blend    = cam2;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out  <= 1'b0;
            sof_out    <= 1'b0;
            update_out <= '0;
        end else if (adv3) begin
            valid_out  <= v2;
            sof_out    <= v2 && sof2;
            update_out <= blend;
        end
    end

`ifdef TRAIL_IIR_STATS_EN
    logic        cam3;
    logic [31:0] cnt;
    logic        take_out;

    assign take_out = valid_out && ready_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cam3           <= 1'b0;
            cnt            <= '0;
            stat_count_out <= '0;
            stat_valid_out <= 1'b0;
        end else begin
            stat_valid_out <= 1'b0;
            if (adv3)
                cam3 <= from_cam;
            if (take_out) begin
                if (sof_out) begin
                    stat_count_out <= cnt;
                    stat_valid_out <= 1'b1;
                    cnt            <= {31'd0, cam3};
                end else if (cam3 && cnt != '1) begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end
`else
    logic unused_src;
    assign unused_src = from_cam;
`endif

endmodule
